// File: rtl/vpu_sram_rd_port_array_pkg.sv
// Shared types and default widths for the VPU SRAM read-port array.
package vpu_sram_rd_port_array_pkg;

    localparam int DEF_NUM_PORTS  = 3;
    localparam int DEF_DATA_W     = 256;
    localparam int DEF_BANK_LG2   = 3;
    localparam int DEF_DEPTH_LG2  = 10;
    localparam int DEF_LEN_W      = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BURST,
        DRAIN
    } vpu_rd_port_state_t;

    // Burst command record at the default widths; len encodes beats-1.
    typedef struct packed {
        logic [DEF_BANK_LG2-1:0]  bank;
        logic [DEF_DEPTH_LG2-1:0] addr;
        logic [DEF_LEN_W-1:0]     len;
    } vpu_rd_cmd_t;

endpackage

// File: rtl/vpu_sram_rd_port_array_port_ctrl.sv
// One SRAM read channel: command latch, bank handshake, credit-limited beat
// issue and a first-word fall-through return buffer toward the core.
module vpu_rd_port_ctrl
    import vpu_sram_rd_port_array_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BANK_LG2   = DEF_BANK_LG2,
    parameter int DEPTH_LG2  = DEF_DEPTH_LG2,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [BANK_LG2-1:0]  cmd_bank,
    input  logic [DEPTH_LG2-1:0] cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 rreq,
    output logic [BANK_LG2-1:0]  rid,
    output logic [DEPTH_LG2-1:0] raddr,
    output logic                 reb,
    output logic                 rlast,
    input  logic                 rack,
    input  logic [DATA_W-1:0]    rdata,
    input  logic                 rvalid,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [DATA_W-1:0]    dout_data,
    output logic                 dout_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    vpu_rd_port_state_t state, state_nx;

    logic [BANK_LG2-1:0]  bank_q;
    logic [DEPTH_LG2-1:0] addr_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     beat_q;
    logic [LEN_W:0]       ret_q;
    logic [CNT_W-1:0]     occ_q;
    logic [CNT_W-1:0]     out_q;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W:0]       in_use;
    logic                 has_credit;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];

    // Buffered entries plus beats still in flight must never exceed the FIFO.
    assign in_use     = {1'b0, occ_q} + {1'b0, out_q};
    assign has_credit = in_use < (CNT_W+1)'(FIFO_DEPTH);
    assign push       = rvalid && (state == BURST || state == DRAIN);
    assign fifo_empty = (occ_q == '0);
    assign pop        = !fifo_empty && dout_ready;

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rreq      = 1'b0;
        reb       = 1'b0;
        rlast     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = REQ;
            end
            REQ: begin
                rreq = 1'b1;
                if (rack) state_nx = BURST;
            end
            BURST: begin
                reb   = has_credit;
                rlast = has_credit && (beat_q == len_q);
                if (rlast) state_nx = DRAIN;
            end
            DRAIN: begin
                if (ret_q == ({1'b0, len_q} + (LEN_W+1)'(1))) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rid   = (state == IDLE)  ? '0 : bank_q;
    assign raddr = (state == BURST) ? addr_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bank_q <= '0;
            addr_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            ret_q  <= '0;
            occ_q  <= '0;
            out_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && cmd_valid) begin
                bank_q <= cmd_bank;
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                beat_q <= '0;
                ret_q  <= '0;
            end
            // Address wraps within the bank; the bank id never changes mid-burst.
            if (reb) begin
                addr_q <= addr_q + DEPTH_LG2'(1);
                beat_q <= beat_q + LEN_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                ret_q  <= ret_q + (LEN_W+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            occ_q <= occ_q + CNT_W'(push) - CNT_W'(pop);
            out_q <= out_q + CNT_W'(reb) - CNT_W'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= rdata;
            mem_last[wr_ptr] <= (ret_q == {1'b0, len_q});
        end
    end

    assign dout_valid = !fifo_empty;
    assign dout_data  = fifo_empty ? '0 : mem_data[rd_ptr];
    assign dout_last  = !fifo_empty && mem_last[rd_ptr];

    // A return into a full buffer means the SRAM ignored the credit limit.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && occ_q == CNT_W'(FIFO_DEPTH) && !pop));

endmodule

// File: rtl/vpu_sram_rd_port_array.sv
// NUM_PORTS independent SRAM read channels; flattened buses carry port 0 in the LSBs.
module vpu_sram_rd_port_array
    import vpu_sram_rd_port_array_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BANK_LG2   = DEF_BANK_LG2,
    parameter int DEPTH_LG2  = DEF_DEPTH_LG2,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           cmd_valid_i,
    output logic [NUM_PORTS-1:0]           cmd_ready_o,
    input  logic [NUM_PORTS*BANK_LG2-1:0]  cmd_bank_i,
    input  logic [NUM_PORTS*DEPTH_LG2-1:0] cmd_addr_i,
    input  logic [NUM_PORTS*LEN_W-1:0]     cmd_len_i,
    output logic [NUM_PORTS-1:0]           rreq_o,
    output logic [NUM_PORTS*BANK_LG2-1:0]  rid_o,
    output logic [NUM_PORTS*DEPTH_LG2-1:0] raddr_o,
    output logic [NUM_PORTS-1:0]           reb_o,
    output logic [NUM_PORTS-1:0]           rlast_o,
    input  logic [NUM_PORTS-1:0]           rack_i,
    input  logic [NUM_PORTS*DATA_W-1:0]    rdata_i,
    input  logic [NUM_PORTS-1:0]           rvalid_i,
    output logic [NUM_PORTS-1:0]           dout_valid_o,
    input  logic [NUM_PORTS-1:0]           dout_ready_i,
    output logic [NUM_PORTS*DATA_W-1:0]    dout_data_o,
    output logic [NUM_PORTS-1:0]           dout_last_o
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        vpu_rd_port_ctrl #(
            .DATA_W     (DATA_W),
            .BANK_LG2   (BANK_LG2),
            .DEPTH_LG2  (DEPTH_LG2),
            .LEN_W      (LEN_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_ctrl (
            .clk        (clk),
            .rst        (rst),
            .cmd_valid  (cmd_valid_i[p]),
            .cmd_ready  (cmd_ready_o[p]),
            .cmd_bank   (cmd_bank_i[p*BANK_LG2 +: BANK_LG2]),
            .cmd_addr   (cmd_addr_i[p*DEPTH_LG2 +: DEPTH_LG2]),
            .cmd_len    (cmd_len_i[p*LEN_W +: LEN_W]),
            .rreq       (rreq_o[p]),
            .rid        (rid_o[p*BANK_LG2 +: BANK_LG2]),
            .raddr      (raddr_o[p*DEPTH_LG2 +: DEPTH_LG2]),
            .reb        (reb_o[p]),
            .rlast      (rlast_o[p]),
            .rack       (rack_i[p]),
            .rdata      (rdata_i[p*DATA_W +: DATA_W]),
            .rvalid     (rvalid_i[p]),
            .dout_valid (dout_valid_o[p]),
            .dout_ready (dout_ready_i[p]),
            .dout_data  (dout_data_o[p*DATA_W +: DATA_W]),
            .dout_last  (dout_last_o[p])
        );
    end

endmodule

// File: tb/tb_vpu_sram_rd_port_array.sv
// Directed bench for vpu_sram_rd_port_array with a per-port SRAM responder model.
module tb_vpu_sram_rd_port_array;
    import vpu_sram_rd_port_array_pkg::*;

    localparam int NP = 3, DW = 256, BW = 3, AW = 10, LW = 8, LOGN = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP-1:0]   cmd_valid_i, cmd_ready_o;
    logic [NP*BW-1:0] cmd_bank_i;
    logic [NP*AW-1:0] cmd_addr_i;
    logic [NP*LW-1:0] cmd_len_i;
    logic [NP-1:0]   rreq_o;
    logic [NP*BW-1:0] rid_o;
    logic [NP*AW-1:0] raddr_o;
    logic [NP-1:0]   reb_o, rlast_o, rack_i, rvalid_i;
    logic [NP*DW-1:0] rdata_i;
    logic [NP-1:0]   dout_valid_o, dout_ready_i, dout_last_o;
    logic [NP*DW-1:0] dout_data_o;

    vpu_sram_rd_port_array dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_bank_i(cmd_bank_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .rreq_o(rreq_o), .rid_o(rid_o), .raddr_o(raddr_o), .reb_o(reb_o), .rlast_o(rlast_o),
        .rack_i(rack_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i),
        .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
        .dout_data_o(dout_data_o), .dout_last_o(dout_last_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int lat [NP];
    int ack_dly [NP];
    vpu_rd_cmd_t cmd_tbl [NP];

    int          ncyc = 0;
    int          reb_n [NP];
    logic [AW-1:0] reb_addr [NP][LOGN];
    logic        reb_last [NP][LOGN];
    logic [BW-1:0] reb_rid [NP][LOGN];
    int          reb_cyc [NP][LOGN];
    int          pop_n [NP];
    logic [DW-1:0] pop_data [NP][LOGN];
    logic        pop_last [NP][LOGN];
    int          pop_cyc [NP][LOGN];

    int          pend_due [NP][256];
    logic [AW-1:0] pend_addr [NP][256];
    int          pend_h [NP];
    int          pend_t [NP];
    int          req_cnt [NP];

    function automatic logic [DW-1:0] sram_data(input int p, input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = '0;
        d[AW-1:0] = a;
        d[15:12] = 4'(p);
        d[100 +: 8] = 8'(p * 37 + 5);
        d[DW-1 -: AW] = ~a;
        return d;
    endfunction

    // Mid-cycle monitor followed by the SRAM model (grant after ack_dly cycles, data lat cycles after each strobe).
    always @(negedge clk) begin
        ncyc++;
        for (int p = 0; p < NP; p++) begin
            if (reb_o[p] && reb_n[p] < LOGN) begin
                reb_addr[p][reb_n[p]] = raddr_o[p*AW +: AW];
                reb_last[p][reb_n[p]] = rlast_o[p];
                reb_rid[p][reb_n[p]]  = rid_o[p*BW +: BW];
                reb_cyc[p][reb_n[p]]  = ncyc;
                reb_n[p]++;
            end
            if (dout_valid_o[p] && dout_ready_i[p] && pop_n[p] < LOGN) begin
                pop_data[p][pop_n[p]] = dout_data_o[p*DW +: DW];
                pop_last[p][pop_n[p]] = dout_last_o[p];
                pop_cyc[p][pop_n[p]]  = ncyc;
                pop_n[p]++;
            end
            if (rst) begin
                pend_h[p]  = 0;
                pend_t[p]  = 0;
                req_cnt[p] = 0;
                rack_i[p]  = 1'b0;
                rvalid_i[p] = 1'b1;
                rdata_i[p*DW +: DW] = '1;
            end else begin
                if (reb_o[p]) begin
                    pend_due[p][pend_t[p] % 256]  = ncyc + lat[p];
                    pend_addr[p][pend_t[p] % 256] = raddr_o[p*AW +: AW];
                    pend_t[p]++;
                end
                rvalid_i[p] = 1'b0;
                rdata_i[p*DW +: DW] = '0;
                if (pend_h[p] != pend_t[p] && pend_due[p][pend_h[p] % 256] <= ncyc) begin
                    rvalid_i[p] = 1'b1;
                    rdata_i[p*DW +: DW] = sram_data(p, pend_addr[p][pend_h[p] % 256]);
                    pend_h[p]++;
                end
                if (rreq_o[p]) begin
                    req_cnt[p]++;
                    rack_i[p] = (req_cnt[p] >= ack_dly[p]);
                end else begin
                    req_cnt[p] = 0;
                    rack_i[p]  = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmds(input logic [NP-1:0] mask, output bit ok);
        tick();
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                cmd_valid_i[p] = 1'b1;
                cmd_bank_i[p*BW +: BW] = cmd_tbl[p].bank;
                cmd_addr_i[p*AW +: AW] = cmd_tbl[p].addr;
                cmd_len_i[p*LW +: LW]  = cmd_tbl[p].len;
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((cmd_ready_o & mask) == mask) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        cmd_valid_i = '0;
    endtask

    task automatic wait_port(input int p, input int pb, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (pop_n[p] - pb >= n && cmd_ready_o[p]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (cmd_ready_o !== 3'b111) $display("[TB] FAIL reset_cmd_ready: got %b expected 111", cmd_ready_o);
        else passes++;
        checks++;
        if (rreq_o !== 3'b000) $display("[TB] FAIL reset_rreq: got %b expected 000", rreq_o);
        else passes++;
        checks++;
        if ({reb_o, rlast_o} !== 6'b0) $display("[TB] FAIL reset_reb_rlast: got %b expected 0", {reb_o, rlast_o});
        else passes++;
        checks++;
        if ({rid_o, raddr_o} !== '0) $display("[TB] FAIL reset_rid_raddr: got %h expected 0", {rid_o, raddr_o});
        else passes++;
        checks++;
        if ({dout_valid_o, dout_last_o} !== 6'b0) $display("[TB] FAIL reset_dout_flags: got %b expected 0", {dout_valid_o, dout_last_o});
        else passes++;
        checks++;
        if (dout_data_o !== '0) $display("[TB] FAIL reset_dout_data: got nonzero expected 0");
        else passes++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        int rb, pb;
        bit ok;
        logic [AW-1:0] exp_a [4];
        exp_a = '{10'h010, 10'h011, 10'h012, 10'h013};
        lat[0] = 1;
        ack_dly[0] = 2;
        cmd_tbl[0] = '{bank: 3'd2, addr: 10'h010, len: 8'd3};
        rb = reb_n[0];
        pb = pop_n[0];
        send_cmds(3'b001, ok);
        wait_port(0, pb, 4, 200, ok);
        checks++;
        if (!ok) $display("[TB] FAIL single_done: got timeout expected 4 beats");
        else passes++;
        checks++;
        if (reb_n[0] - rb != 4) $display("[TB] FAIL single_reb_count: got %0d expected 4", reb_n[0] - rb);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (reb_addr[0][rb+i] !== exp_a[i] || reb_last[0][rb+i] !== (i == 3) || reb_rid[0][rb+i] !== 3'd2)
                $display("[TB] FAIL single_beat%0d: got addr %h last %b rid %0d expected addr %h last %b rid 2",
                         i, reb_addr[0][rb+i], reb_last[0][rb+i], reb_rid[0][rb+i], exp_a[i], (i == 3));
            else passes++;
            checks++;
            if (pop_data[0][pb+i] !== sram_data(0, exp_a[i]) || pop_last[0][pb+i] !== (i == 3))
                $display("[TB] FAIL single_dout%0d: got %h last %b expected %h last %b", i,
                         pop_data[0][pb+i], pop_last[0][pb+i], sram_data(0, exp_a[i]), (i == 3));
            else passes++;
        end
        checks++;
        if (cmd_ready_o[0] !== 1'b1) $display("[TB] FAIL single_cmd_ready: got %b expected 1", cmd_ready_o[0]);
        else passes++;
    endtask

    task automatic test_addr_wrap();
        int rb, pb;
        bit ok;
        logic [AW-1:0] exp_a [4];
        exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        lat[1] = 2;
        ack_dly[1] = 1;
        cmd_tbl[1] = '{bank: 3'd5, addr: 10'h3FE, len: 8'd3};
        rb = reb_n[1];
        pb = pop_n[1];
        send_cmds(3'b010, ok);
        wait_port(1, pb, 4, 200, ok);
        checks++;
        if (!ok || reb_n[1] - rb != 4) $display("[TB] FAIL wrap_count: got %0d beats expected 4", reb_n[1] - rb);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (reb_addr[1][rb+i] !== exp_a[i] || reb_rid[1][rb+i] !== 3'd5)
                $display("[TB] FAIL wrap_beat%0d: got addr %h rid %0d expected addr %h rid 5",
                         i, reb_addr[1][rb+i], reb_rid[1][rb+i], exp_a[i]);
            else passes++;
        end
        checks++;
        if (pop_data[1][pb+2] !== sram_data(1, 10'h000)) $display("[TB] FAIL wrap_dout2: got %h expected %h",
                pop_data[1][pb+2], sram_data(1, 10'h000));
        else passes++;
    endtask

    task automatic test_credit_stall();
        int rb, pb, bad;
        bit ok;
        lat[0] = 3;
        ack_dly[0] = 0;
        cmd_tbl[0] = '{bank: 3'd1, addr: 10'h100, len: 8'd7};
        rb = reb_n[0];
        pb = pop_n[0];
        dout_ready_i[0] = 1'b0;
        send_cmds(3'b001, ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (reb_n[0] - rb >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || reb_n[0] - rb != 4) $display("[TB] FAIL stall_reb_count: got %0d expected 4", reb_n[0] - rb);
        else passes++;
        checks++;
        if (dout_valid_o[0] !== 1'b1) $display("[TB] FAIL stall_dout_valid: got %b expected 1", dout_valid_o[0]);
        else passes++;
        tick();
        dout_ready_i[0] = 1'b1;
        wait_port(0, pb, 8, 300, ok);
        checks++;
        if (!ok || reb_n[0] - rb != 8) $display("[TB] FAIL stall_total: got %0d beats expected 8", reb_n[0] - rb);
        else passes++;
        checks++;
        if (reb_cyc[0][rb+4] - pop_cyc[0][pb] != 1)
            $display("[TB] FAIL stall_resume: got %0d cycles expected 1", reb_cyc[0][rb+4] - pop_cyc[0][pb]);
        else passes++;
        bad = 0;
        for (int i = 0; i < 8; i++)
            if (pop_data[0][pb+i] !== sram_data(0, 10'h100 + 10'(i)) || pop_last[0][pb+i] !== (i == 7)) bad++;
        checks++;
        if (bad != 0) $display("[TB] FAIL stall_order: got %0d bad beats expected 0", bad);
        else passes++;
    endtask

    task automatic test_concurrent();
        int rb [NP], pb [NP];
        int n, bad;
        bit ok;
        cmd_tbl[0] = '{bank: 3'd1, addr: 10'h020, len: 8'd0};
        cmd_tbl[1] = '{bank: 3'd3, addr: 10'h155, len: 8'd5};
        cmd_tbl[2] = '{bank: 3'd6, addr: 10'h380, len: 8'd255};
        ack_dly = '{0, 3, 6};
        lat = '{1, 2, 4};
        for (int p = 0; p < NP; p++) begin
            rb[p] = reb_n[p];
            pb[p] = pop_n[p];
        end
        send_cmds(3'b111, ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (pop_n[0] - pb[0] >= 1 && pop_n[1] - pb[1] >= 6 && pop_n[2] - pb[2] >= 256 && cmd_ready_o == 3'b111) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) $display("[TB] FAIL conc_done: got timeout expected all ports idle");
        else passes++;
        checks++;
        if (reb_last[0][rb[0]] !== 1'b1) $display("[TB] FAIL conc_len0_rlast: got %b expected 1", reb_last[0][rb[0]]);
        else passes++;
        for (int p = 0; p < NP; p++) begin
            n = int'(cmd_tbl[p].len) + 1;
            checks++;
            if (reb_n[p] - rb[p] != n || pop_n[p] - pb[p] != n)
                $display("[TB] FAIL conc_p%0d_count: got reb %0d dout %0d expected %0d", p, reb_n[p] - rb[p], pop_n[p] - pb[p], n);
            else passes++;
            bad = 0;
            for (int i = 0; i < n; i++) begin
                if (reb_addr[p][rb[p]+i] !== cmd_tbl[p].addr + 10'(i)) bad++;
                if (reb_last[p][rb[p]+i] !== (i == n - 1)) bad++;
                if (reb_rid[p][rb[p]+i] !== cmd_tbl[p].bank) bad++;
            end
            checks++;
            if (bad != 0) $display("[TB] FAIL conc_p%0d_strobes: got %0d bad fields expected 0", p, bad);
            else passes++;
            bad = 0;
            for (int i = 0; i < n; i++) begin
                if (pop_data[p][pb[p]+i] !== sram_data(p, cmd_tbl[p].addr + 10'(i))) bad++;
                if (pop_last[p][pb[p]+i] !== (i == n - 1)) bad++;
            end
            checks++;
            if (bad != 0) $display("[TB] FAIL conc_p%0d_dout: got %0d bad beats expected 0", p, bad);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int rb, pb, bad;
        bit ok;
        lat = '{1, 1, 1};
        ack_dly = '{0, 0, 0};
        cmd_tbl[0] = '{bank: 3'd4, addr: 10'h040, len: 8'd5};
        rb = reb_n[0];
        send_cmds(3'b001, ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (reb_n[0] - rb >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || cmd_ready_o !== 3'b111 || rreq_o !== 3'b000 || reb_o !== 3'b000 || rlast_o !== 3'b000)
            $display("[TB] FAIL rstmid_ctrl: got ready %b rreq %b reb %b rlast %b expected 111 000 000 000",
                     cmd_ready_o, rreq_o, reb_o, rlast_o);
        else passes++;
        checks++;
        if (dout_valid_o !== 3'b000 || dout_last_o !== 3'b000 || dout_data_o !== '0)
            $display("[TB] FAIL rstmid_fifo: got valid %b last %b expected 000 000", dout_valid_o, dout_last_o);
        else passes++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dout_valid_o !== 3'b000 || cmd_ready_o !== 3'b111)
            $display("[TB] FAIL rstmid_ignore_rvalid: got valid %b ready %b expected 000 111", dout_valid_o, cmd_ready_o);
        else passes++;
        cmd_tbl[0] = '{bank: 3'd4, addr: 10'h200, len: 8'd3};
        rb = reb_n[0];
        pb = pop_n[0];
        send_cmds(3'b001, ok);
        wait_port(0, pb, 4, 200, ok);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (pop_data[0][pb+i] !== sram_data(0, 10'h200 + 10'(i)) || pop_last[0][pb+i] !== (i == 3)) bad++;
        checks++;
        if (!ok || reb_n[0] - rb != 4 || bad != 0)
            $display("[TB] FAIL rstmid_recover: got %0d beats %0d bad expected 4 beats 0 bad", reb_n[0] - rb, bad);
        else passes++;
    endtask

    task automatic test_no_ack();
        int rb, bad_req, bad_reb, bad_rdy;
        bit ok;
        ack_dly[1] = 1000000;
        cmd_tbl[1] = '{bank: 3'd7, addr: 10'h0AA, len: 8'd2};
        rb = reb_n[1];
        send_cmds(3'b010, ok);
        bad_req = 0;
        bad_reb = 0;
        bad_rdy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rreq_o[1] !== 1'b1) bad_req++;
            if (reb_o[1] !== 1'b0) bad_reb++;
            if (cmd_ready_o[1] !== 1'b0) bad_rdy++;
        end
        checks++;
        if (!ok || bad_req != 0) $display("[TB] FAIL noack_rreq: got %0d cycles low expected 0", bad_req);
        else passes++;
        checks++;
        if (bad_reb != 0 || reb_n[1] != rb) $display("[TB] FAIL noack_reb: got %0d strobes expected 0", bad_reb);
        else passes++;
        checks++;
        if (bad_rdy != 0) $display("[TB] FAIL noack_cmd_ready: got %0d cycles high expected 0", bad_rdy);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_i = '0;
        cmd_bank_i = '0;
        cmd_addr_i = '0;
        cmd_len_i = '0;
        dout_ready_i = '1;
        for (int p = 0; p < NP; p++) begin
            lat[p] = 1;
            ack_dly[p] = 0;
            cmd_tbl[p] = '0;
        end
        test_reset();
        test_single_burst();
        test_addr_wrap();
        test_credit_stall();
        test_concurrent();
        test_reset_mid_burst();
        test_no_ack();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vpu_sram_rd_port_array.md
Name: vpu_sram_rd_port_array

Overview:
- Parametrised successor to the fixed three-source read-port front end of the VPU.
- Provides NUM_PORTS independent SRAM read channels. Each channel takes a burst command (bank, start address, length) from the VPU core and runs the bank request/ack handshake.
- Each channel issues per-beat read strobes with auto-incrementing addresses and buffers the returned data in a credit-protected FIFO toward the core.
- SRAM-side buses are flattened per port, lowest index in the LSBs.

Parameters:
- NUM_PORTS, 3: number of read channels.
- DATA_W, 256: SRAM data width.
- BANK_LG2, 3: bank-id width.
- DEPTH_LG2, 10: bank address width.
- LEN_W, 8: burst length field width (encodes beats-1).
- FIFO_DEPTH, 4: per-port return buffer entries. Must be a power of two and ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cmd_valid_i  in  NUM_PORTS  per-port command valid.
- cmd_ready_o  out  NUM_PORTS  per-port command accept.
- cmd_bank_i  in  NUM_PORTS*BANK_LG2  target bank.
- cmd_addr_i  in  NUM_PORTS*DEPTH_LG2  start address.
- cmd_len_i  in  NUM_PORTS*LEN_W  beats-1.
- rreq_o  out  NUM_PORTS  bank request.
- rid_o  out  NUM_PORTS*BANK_LG2  requested bank.
- raddr_o  out  NUM_PORTS*DEPTH_LG2  beat address.
- reb_o  out  NUM_PORTS  read beat strobe (active-high, one beat per cycle asserted).
- rlast_o  out  NUM_PORTS  marks final beat strobe.
- rack_i  in  NUM_PORTS  bank grant.
- rdata_i  in  NUM_PORTS*DATA_W  returned data.
- rvalid_i  in  NUM_PORTS  returned data valid.
- dout_valid_o  out  NUM_PORTS  buffered data valid.
- dout_ready_i  in  NUM_PORTS  core accepts data.
- dout_data_o  out  NUM_PORTS*DATA_W  buffered data.
- dout_last_o  out  NUM_PORTS  final beat of burst.

Behaviour:
- Reset and clocking: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready_o = all ones. All FSMs go to IDLE, FIFOs flush, counters clear.
- Reset mid-burst: the burst is abandoned with no rlast. The SRAM side is reset in the same cycle; rvalid_i during rst is ignored.
- Ports are fully independent; no cross-port arbitration inside the block.
- FSM per port:
  - IDLE: cmd_ready=1. On cmd_valid, latch bank/addr/len, go to REQ.
  - REQ: rreq=1, rid=latched bank. Stay until rack_i=1, then go to BURST. rreq deasserts in the cycle after rack is sampled.
  - BURST: reb=1 in any cycle where credit > 0. raddr = current address. rlast=1 on beat number len. After each beat, address increments mod 2^DEPTH_LG2 (wraps 1023 -> 0, bank unchanged). After the last beat strobe, go to DRAIN.
  - DRAIN: wait until returned-beat count = len+1, then go to IDLE.
- Command timing: a new command is accepted only in IDLE; no command overlap. Minimum cmd-to-rreq latency is 1 cycle.
- Credit: credit = FIFO_DEPTH - (FIFO occupancy + beats outstanding).
  - Outstanding increments on reb and decrements on rvalid_i.
  - Simultaneous reb and rvalid leaves outstanding unchanged.
  - A FIFO pop in the same cycle frees credit in the next cycle.
- Returns: rvalid_i data is in order and variable latency ≥1 cycle. rvalid_i arriving when the FIFO would overflow is a protocol error; flag it with an assertion, never drop silently.
- FIFO: first-word fall-through; dout_valid = !empty. A push to an empty FIFO makes dout_valid rise the next cycle. Push and pop in the same cycle are allowed at full or empty.
- dout_last: set on the entry whose return index = len. The return-beat counter is LEN_W+1 bits.
- len = 2^LEN_W - 1 (256 beats) is legal. len=0 gives a single beat with reb and rlast in the same cycle.

Decomposition:
- Package: vpu_rd_port_state_t enum {IDLE, REQ, BURST, DRAIN}; default width constants; a vpu_rd_cmd_t struct {bank, addr, len}.
- Sub-module vpu_rd_port_ctrl holds one channel's FSM, counters, credit logic and FIFO. The top generates NUM_PORTS instances and slices the flattened buses.

Test Plan:
- Port0 cmd bank=2 addr=0x010 len=3; rack after 2 cycles; rvalid 1 cycle after each reb -> 4 reb at raddr 0x010..0x013, rlast on 0x013, 4 dout beats with dout_last on the 4th, then cmd_ready returns to 1.
- Port1 addr=0x3FE len=3 -> raddr sequence 0x3FE, 0x3FF, 0x000, 0x001; rid stays constant.
- FIFO_DEPTH=4, len=7, dout_ready=0, rvalid delay 3 -> exactly 4 reb issued and then stalled. Raising dout_ready resumes reb one cycle after the first pop; all 8 beats are delivered in order.
- All three ports driven concurrently with different lengths (0, 5, 255) and staggered rack -> each port's streams are independent and correct. The len=0 port shows reb and rlast in the same cycle.
- rst asserted in BURST after 2 of 6 beats -> next cycle: all outputs at reset values, FIFO empty. A new command then completes normally.
- rack_i held 0 for 50 cycles -> rreq stays 1, no reb, and cmd_ready stays 0.
